// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// instruction register, ALU control, immediate generation and memory/PC strobes.
module multicycle_control #(
  parameter int XLEN            = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ack,
  input  logic [31:0]     instr,
  input  logic            dmem_ack,
  input  logic            br_taken,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            rf_we,
  output logic            alu_imm,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      wb_sel,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            illegal,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  function automatic logic [XLEN-1:0] sign_ext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal_q;
  logic        set_illegal;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_branch, is_legal;
  logic        imem_req_c, dmem_req_c, rf_we_c, pc_we_c, pc_sel_c;
  logic        alu_imm_c;
  logic [2:0]  funct3_c;
  logic [6:0]  funct7_c;
  logic [1:0]  wb_sel_c;
  logic signed [31:0] imm32;

  assign opcode    = ir_q[6:0];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_legal  = (opcode == OPC_OP_IMM) || (opcode == OPC_OP) || is_load ||
                     is_store || is_branch || (opcode == OPC_LUI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ack)
        ir_q <= instr;
      if (set_illegal)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    rf_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: begin
        if (is_legal) begin
          state_d = EXEC;
        end else begin
          set_illegal = 1'b1;
          if (HALT_ON_ILLEGAL) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            pc_we_c = 1'b1;
          end
        end
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_branch) begin
          state_d  = FETCH;
          pc_we_c  = 1'b1;
          pc_sel_c = br_taken;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ack) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            pc_we_c = 1'b1;
          end
        end
      end
      WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls depend only on the latched instruction word.
  always_comb begin
    imm32     = '0;
    alu_imm_c = 1'b0;
    funct3_c  = 3'd0;
    funct7_c  = 7'd0;
    wb_sel_c  = 2'd0;
    case (opcode)
      OPC_OP: begin
        funct3_c = ir_q[14:12];
        funct7_c = ir_q[31:25];
      end
      OPC_OP_IMM: begin
        alu_imm_c = 1'b1;
        funct3_c  = ir_q[14:12];
        funct7_c  = (ir_q[14:12] == 3'b101) ? ir_q[31:25] : 7'd0;
        imm32     = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_LOAD: begin
        alu_imm_c = 1'b1;
        wb_sel_c  = 2'd1;
        imm32     = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_STORE: begin
        alu_imm_c = 1'b1;
        imm32     = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OPC_BRANCH: begin
        funct3_c = ir_q[14:12];
        funct7_c = 7'b0100000;
        imm32    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      OPC_LUI: begin
        wb_sel_c = 2'd2;
        imm32    = {ir_q[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Reset forces every output low in the same cycle, cancelling in-flight accesses.
  assign imem_req   = imem_req_c & ~rst;
  assign dmem_req   = dmem_req_c & ~rst;
  assign dmem_we    = dmem_req_c & is_store & ~rst;
  assign rf_we      = rf_we_c & ~rst;
  assign pc_we      = pc_we_c & ~rst;
  assign pc_sel     = pc_sel_c & ~rst;
  assign alu_imm    = alu_imm_c & ~rst;
  assign alu_funct3 = rst ? 3'd0 : funct3_c;
  assign alu_funct7 = rst ? 7'd0 : funct7_c;
  assign wb_sel     = rst ? 2'd0 : wb_sel_c;
  assign imm        = rst ? '0 : sign_ext(imm32);
  assign illegal    = illegal_q & ~rst;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a 64-bit halting instance and a 32-bit
// skip-on-illegal instance share one stimulus stream.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst, imem_ack, dmem_ack, br_taken;
  logic [31:0] instr;

  logic        a_imem_req, a_dmem_req, a_dmem_we, a_rf_we, a_alu_imm, a_pc_we, a_pc_sel, a_illegal;
  logic [2:0]  a_funct3, a_state;
  logic [6:0]  a_funct7;
  logic [63:0] a_imm;
  logic [1:0]  a_wb_sel;

  logic        b_imem_req, b_dmem_req, b_dmem_we, b_rf_we, b_alu_imm, b_pc_we, b_pc_sel, b_illegal;
  logic [2:0]  b_funct3, b_state;
  logic [6:0]  b_funct7;
  logic [31:0] b_imm;
  logic [1:0]  b_wb_sel;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.XLEN(64), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .imem_ack(imem_ack), .instr(instr), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(a_imem_req), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
    .rf_we(a_rf_we), .alu_imm(a_alu_imm), .alu_funct3(a_funct3), .alu_funct7(a_funct7),
    .imm(a_imm), .wb_sel(a_wb_sel), .pc_we(a_pc_we), .pc_sel(a_pc_sel),
    .illegal(a_illegal), .state(a_state)
  );

  multicycle_control #(.XLEN(32), .HALT_ON_ILLEGAL(1'b0)) dut_skip (
    .clk(clk), .rst(rst), .imem_ack(imem_ack), .instr(instr), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(b_imem_req), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
    .rf_we(b_rf_we), .alu_imm(b_alu_imm), .alu_funct3(b_funct3), .alu_funct7(b_funct7),
    .imm(b_imm), .wb_sel(b_wb_sel), .pc_we(b_pc_we), .pc_sel(b_pc_sel),
    .illegal(b_illegal), .state(b_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word with an immediate ack; returns in DECODE with instr scrambled.
  task automatic fetch(input logic [31:0] w);
    instr    = w;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    instr    = 32'hFFFF_FFFF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; instr = 32'h0;
    run(2);
    chk("rst_state",    a_state, 0);
    chk("rst_imem_req", a_imem_req, 0);
    chk("rst_illegal",  a_illegal, 0);
    chk("rst_pc_we",    a_pc_we, 0);
    chk("rst_imm",      a_imm, 0);
    rst = 1'b0;
    #1;
    chk("fetch_imem_req", a_imem_req, 1);
    tick();
    chk("fetch_wait_state", a_state, 0);

    // ADDI x1,x0,-1
    fetch(32'hFFF00093);
    chk("addi_state",   a_state, 1);
    chk("addi_imm64",   a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm32",   b_imm, 64'h0000_0000_FFFF_FFFF);
    chk("addi_alu_imm", a_alu_imm, 1);
    chk("addi_funct7",  a_funct7, 0);
    tick();
    chk("addi_exec_state", a_state, 2);
    chk("addi_exec_rf_we", a_rf_we, 0);
    tick();
    chk("addi_wb_state",  a_state, 4);
    chk("addi_wb_rf_we",  a_rf_we, 1);
    chk("addi_wb_pc_we",  a_pc_we, 1);
    chk("addi_wb_pc_sel", a_pc_sel, 0);
    chk("addi_wb_sel",    a_wb_sel, 0);
    tick();
    chk("addi_back_state", a_state, 0);
    chk("addi_back_rf_we", a_rf_we, 0);

    // SRAI x1,x1,3 and SUB x3,x1,x2
    fetch(32'h4030D093);
    chk("srai_funct3", a_funct3, 5);
    chk("srai_funct7", a_funct7, 7'h20);
    chk("srai_imm",    a_imm, 64'h403);
    run(3);
    fetch(32'h402081B3);
    chk("sub_funct7",  a_funct7, 7'h20);
    chk("sub_alu_imm", a_alu_imm, 0);
    chk("sub_imm",     a_imm, 0);
    run(3);

    // LW x5,4(x2) with dmem_ack three cycles late
    fetch(32'h00412283);
    tick();
    chk("lw_alu_imm", a_alu_imm, 1);
    chk("lw_funct3",  a_funct3, 0);
    chk("lw_wb_sel",  a_wb_sel, 1);
    chk("lw_imm",     a_imm, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_state", a_state, 3);
      chk("lw_dmem_req",  a_dmem_req, 1);
      chk("lw_dmem_we",   a_dmem_we, 0);
      if (i == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    chk("lw_wb_state",    a_state, 4);
    chk("lw_wb_rf_we",    a_rf_we, 1);
    chk("lw_wb_sel2",     a_wb_sel, 1);
    chk("lw_wb_dmem_req", a_dmem_req, 0);
    tick();
    chk("lw_back_state", a_state, 0);

    // BEQ x1,x2,-8 taken, then not taken
    fetch(32'hFE208CE3);
    br_taken = 1'b1;
    tick();
    chk("beq_pc_we",  a_pc_we, 1);
    chk("beq_pc_sel", a_pc_sel, 1);
    chk("beq_rf_we",  a_rf_we, 0);
    chk("beq_imm64",  a_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_imm32",  b_imm, 64'h0000_0000_FFFF_FFF8);
    chk("beq_funct7", a_funct7, 7'h20);
    br_taken = 1'b0;
    tick();
    chk("beq_back_state", a_state, 0);
    fetch(32'hFE208CE3);
    tick();
    chk("bne_pc_we",  a_pc_we, 1);
    chk("bne_pc_sel", a_pc_sel, 0);
    tick();

    // SW x5,8(x2), ack already high before MEM
    fetch(32'h00512423);
    tick();
    chk("sw_imm",     a_imm, 8);
    chk("sw_alu_imm", a_alu_imm, 1);
    chk("sw_exec_dmem_we", a_dmem_we, 0);
    dmem_ack = 1'b1;
    tick();
    chk("sw_dmem_req", a_dmem_req, 1);
    chk("sw_dmem_we",  a_dmem_we, 1);
    chk("sw_pc_we",    a_pc_we, 1);
    chk("sw_pc_sel",   a_pc_sel, 0);
    tick();
    dmem_ack = 1'b0;
    chk("sw_back_state", a_state, 0);

    // SW interrupted by reset in MEM
    fetch(32'h00512423);
    run(2);
    chk("swr_dmem_req", a_dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("swr_rst_dmem_req", a_dmem_req, 0);
    chk("swr_rst_pc_we",    a_pc_we, 0);
    tick();
    chk("swr_state",    a_state, 0);
    chk("swr_dmem_req2", a_dmem_req, 0);
    chk("swr_pc_we2",   a_pc_we, 0);
    chk("swr_imem_req", a_imem_req, 0);
    rst = 1'b0;
    #1;
    chk("swr_release_imem_req", a_imem_req, 1);

    // LUI x7,0x12345
    fetch(32'h123453B7);
    chk("lui_imm64",   a_imm, 64'h0000_0000_1234_5000);
    chk("lui_imm32",   b_imm, 64'h1234_5000);
    chk("lui_wb_sel",  a_wb_sel, 2);
    chk("lui_alu_imm", a_alu_imm, 0);
    run(2);
    chk("lui_wb_rf_we", a_rf_we, 1);
    tick();

    // Illegal opcode 1111111
    fetch(32'h0000007F);
    chk("ill_halt_pc_we",  a_pc_we, 0);
    chk("ill_skip_pc_we",  b_pc_we, 1);
    chk("ill_skip_pc_sel", b_pc_sel, 0);
    chk("ill_pre_sticky",  a_illegal, 0);
    tick();
    chk("ill_halt_state",    a_state, 5);
    chk("ill_halt_illegal",  a_illegal, 1);
    chk("ill_halt_imem_req", a_imem_req, 0);
    chk("ill_skip_state",    b_state, 0);
    chk("ill_skip_illegal",  b_illegal, 1);
    chk("ill_skip_imem_req", b_imem_req, 1);
    chk("ill_skip_pc_we2",   b_pc_we, 0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("ill_halt_stays", a_state, 5);
    chk("ill_halt_pc_we2", a_pc_we, 0);

    rst = 1'b1;
    tick();
    chk("final_rst_illegal", a_illegal, 0);
    chk("final_rst_state",   a_state, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
